// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg_pkg
// Brief    : Shared glyph constants and state encodings for seg_scan_ctrl.
// Revision : 1.0
// ============================================================================
package seg_pkg;

    localparam logic [6:0] SEG_BLANK  = 7'h7F;
    localparam logic [6:0] SEG_DASH   = 7'b1111110;
    localparam logic [6:0] SEG_ERR    = 7'b0110110;
    localparam logic [7:0] CHAR_SPACE = 8'h20;

    typedef enum logic [0:0] {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        CLEARING = 1'b1
    } ctrl_state_t;

endpackage
`default_nettype wire

// File: rtl/ascii_seg_decode.sv
`default_nettype none
// ============================================================================
// Module   : ascii_seg_decode
// Brief    : ASCII to active-low 7-segment glyph {a,b,c,d,e,f,g}.
// Revision : 1.0
// ============================================================================
module ascii_seg_decode
    import seg_pkg::*;
(
    input  logic [7:0] i_char,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_ERR;
        case (i_char)
            8'h30:        o_seg = 7'b0000001;
            8'h31:        o_seg = 7'b1001111;
            8'h32:        o_seg = 7'b0010010;
            8'h33:        o_seg = 7'b0000110;
            8'h34:        o_seg = 7'b1001100;
            8'h35:        o_seg = 7'b0100100;
            8'h36:        o_seg = 7'b0100000;
            8'h37:        o_seg = 7'b0001111;
            8'h38:        o_seg = 7'b0000000;
            8'h39:        o_seg = 7'b0000100;
            // Upper and lower case letters share the hex glyph set A,b,C,d,E,F
            8'h41, 8'h61: o_seg = 7'b0001000;
            8'h42, 8'h62: o_seg = 7'b1100000;
            8'h43, 8'h63: o_seg = 7'b0110001;
            8'h44, 8'h64: o_seg = 7'b1000010;
            8'h45, 8'h65: o_seg = 7'b0110000;
            8'h46, 8'h66: o_seg = 7'b0111000;
            CHAR_SPACE:   o_seg = SEG_BLANK;
            8'h2D:        o_seg = SEG_DASH;
            default:      o_seg = SEG_ERR;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_ctrl
// Brief    : Multiplexed 7-segment controller: char buffer, decode, blanked scan.
// Revision : 1.0
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [7:0]            wr_char,
    input  logic                  clear,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int c_span  = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int c_cnt_w = $clog2(c_span + 1);
    localparam int c_idx_w = $clog2(NUM_DIGITS);
    localparam int c_clr_w = $clog2(NUM_DIGITS + 1);

    localparam logic [c_cnt_w-1:0]    c_show_last  = c_cnt_w'(REFRESH_DIV - 1);
    localparam logic [c_cnt_w-1:0]    c_blank_last = c_cnt_w'(BLANK_CYCLES - 1);
    localparam logic [c_idx_w-1:0]    c_idx_last   = c_idx_w'(NUM_DIGITS - 1);
    localparam logic [c_clr_w-1:0]    c_clr_last   = c_clr_w'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] c_one_hot    = NUM_DIGITS'(1);

    scan_state_t        r_scan, w_scan_nxt;
    ctrl_state_t        r_ctrl, w_ctrl_nxt;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_idx_w-1:0] r_idx;
    logic [c_clr_w-1:0] r_clr_cnt;
    logic [7:0]         r_buf [NUM_DIGITS];
    logic               w_shift;
    logic [7:0]         w_shift_char;
    logic [6:0]         w_glyph;

    // ---------------------------------------------------------------- scan FSM
    always_comb begin
        w_scan_nxt = r_scan;
        case (r_scan)
            BLANK:   if (r_cnt == c_blank_last) w_scan_nxt = SHOW;
            SHOW:    if (r_cnt == c_show_last)  w_scan_nxt = BLANK;
            default: w_scan_nxt = BLANK;
        endcase
    end

    // idx advances when a digit goes dark, so the first lit digit after reset is 0
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scan <= BLANK;
            r_cnt  <= '0;
            r_idx  <= '0;
        end else begin
            r_scan <= w_scan_nxt;
            r_cnt  <= (w_scan_nxt != r_scan) ? '0 : r_cnt + c_cnt_w'(1);
            if (r_scan == SHOW && w_scan_nxt == BLANK)
                r_idx <= (r_idx == c_idx_last) ? '0 : r_idx + c_idx_w'(1);
        end
    end

    // ---------------------------------------------------------------- ctrl FSM
    always_comb begin
        w_ctrl_nxt   = r_ctrl;
        wr_ready     = 1'b0;
        w_shift      = 1'b0;
        w_shift_char = wr_char;
        case (r_ctrl)
            IDLE: begin
                wr_ready = !clear;
                if (clear)
                    w_ctrl_nxt = CLEARING;
                else if (wr_valid)
                    w_shift = 1'b1;
            end
            CLEARING: begin
                w_shift      = 1'b1;
                w_shift_char = CHAR_SPACE;
                if (r_clr_cnt == c_clr_last)
                    w_ctrl_nxt = IDLE;
            end
            default: w_ctrl_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ctrl    <= IDLE;
            r_clr_cnt <= '0;
        end else begin
            r_ctrl    <= w_ctrl_nxt;
            r_clr_cnt <= (r_ctrl == CLEARING) ? r_clr_cnt + c_clr_w'(1) : '0;
        end
    end

    // ------------------------------------------------------- character buffer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < NUM_DIGITS; k++)
                r_buf[k] <= CHAR_SPACE;
        end else if (w_shift) begin
            for (int k = NUM_DIGITS - 1; k > 0; k--)
                r_buf[k] <= r_buf[k-1];
            r_buf[0] <= w_shift_char;
        end
    end

    ascii_seg_decode u_decode (
        .i_char (r_buf[r_idx]),
        .o_seg  (w_glyph)
    );

    // ------------------------------------------------------- registered pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= SEG_BLANK;
            an  <= '1;
        end else if (r_scan == SHOW) begin
            seg <= w_glyph;
            an  <= ~(c_one_hot << r_idx);
        end else begin
            seg <= SEG_BLANK;
            an  <= '1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_ctrl
// Brief    : Self-checking bench for seg_scan_ctrl against a timeline model.
// Revision : 1.0
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int ND  = 4;
    localparam int RD  = 4;
    localparam int BC  = 2;
    localparam int PER = RD + BC;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic          wr_valid = 1'b0;
    logic          clear    = 1'b0;
    logic [7:0]    wr_char  = 8'h00;
    logic          wr_ready;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    int         checks = 0;
    int         errors = 0;
    int         n      = 0;   // clock edges since reset release
    int         clr_left = 0; // remaining clearing cycles in the model
    logic [7:0] q[$];         // q[0] is the rightmost (newest) character
    logic       last_rdy;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_char  (wr_char),
        .clear    (clear),
        .seg      (seg),
        .an       (an)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] glyph(input logic [7:0] c);
        case (c)
            "0": return 7'b0000001;
            "1": return 7'b1001111;
            "2": return 7'b0010010;
            "3": return 7'b0000110;
            "4": return 7'b1001100;
            "5": return 7'b0100100;
            "6": return 7'b0100000;
            "7": return 7'b0001111;
            "8": return 7'b0000000;
            "9": return 7'b0000100;
            "A", "a": return 7'b0001000;
            "B", "b": return 7'b1100000;
            "C", "c": return 7'b0110001;
            "D", "d": return 7'b1000010;
            "E", "e": return 7'b0110000;
            "F", "f": return 7'b0111000;
            " ": return 7'b1111111;
            "-": return 7'b1111110;
            default: return 7'b0110110;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q = {};
        repeat (ND) q.push_back(8'h20);
        clr_left = 0;
        n = 0;
    endtask

    task automatic model_shift(input logic [7:0] c);
        q.push_front(c);
        void'(q.pop_back());
    endtask

    function automatic bit lit_now(input int edges);
        return (edges > 0) && (((edges - 1) % PER) >= BC);
    endfunction

    function automatic int digit_now(input int edges);
        return ((edges - 1) / PER) % ND;
    endfunction

    // One clock: check wr_ready for the driven inputs, advance the model,
    // then check the registered pins after the edge.
    task automatic step();
        logic [7:0]    qold[$];
        logic [6:0]    es;
        logic [ND-1:0] ea;
        bit            exp_rdy;
        #1;
        exp_rdy  = (clr_left == 0) && !clear;
        last_rdy = wr_ready;
        chk("wr_ready", {31'd0, wr_ready}, {31'd0, exp_rdy});
        qold = q;
        if (clr_left > 0) begin
            model_shift(8'h20);
            clr_left--;
        end else if (clear) begin
            clr_left = ND;
        end else if (wr_valid) begin
            model_shift(wr_char);
        end
        @(posedge clk);
        #1;
        n++;
        if (lit_now(n)) begin
            ea = ~(ND'(1) << digit_now(n));
            es = glyph(qold[digit_now(n)]);
        end else begin
            ea = '1;
            es = 7'h7F;
        end
        chk("an", {28'd0, an}, {28'd0, ea});
        chk("seg", {25'd0, seg}, {25'd0, es});
    endtask

    initial begin
        logic [7:0] txt[4];
        int         acc;
        int         low;
        bit         found;
        int         r;

        model_reset();
        #12;
        chk("reset_an", {28'd0, an}, 32'hF);
        chk("reset_seg", {25'd0, seg}, 32'h7F);
        chk("reset_rdy", {31'd0, wr_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;

        // idle scan through more than one full 24-cycle rotation
        repeat (30) step();

        // back-to-back writes "1234"
        txt[0] = "1"; txt[1] = "2"; txt[2] = "3"; txt[3] = "4";
        acc = 0;
        wr_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_char = txt[i];
            step();
            if (last_rdy) acc++;
        end
        wr_valid = 1'b0;
        chk("accepts_1234", acc, 4);
        repeat (30) step();

        // 'A' then an unsupported code
        wr_valid = 1'b1;
        wr_char = "A";
        step();
        wr_char = 8'h7E;
        step();
        wr_valid = 1'b0;
        repeat (30) step();

        // clear with a simultaneous write: write lost, ready low 4 cycles
        clear = 1'b1; wr_valid = 1'b1; wr_char = "5";
        step();
        clear = 1'b0; wr_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (!last_rdy) low++;
        end
        chk("clear_low_cycles", low, 4);
        repeat (26) step();
        wr_valid = 1'b1; wr_char = "7";
        step();
        wr_valid = 1'b0;
        chk("write_after_clear", {31'd0, last_rdy}, 32'd1);
        repeat (24) step();

        // second clear pulse during clearing is ignored
        clear = 1'b1;
        step();
        low = 0;
        for (int i = 0; i < 8; i++) begin
            clear = (i == 1);
            step();
            if (!last_rdy) low++;
        end
        clear = 1'b0;
        chk("clear_retrigger_low", low, 4);

        // randomized traffic
        for (int i = 0; i < 500; i++) begin
            r = $urandom_range(0, 99);
            clear    = (r < 4);
            wr_valid = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 5))
                0: wr_char = 8'h30 + 8'($urandom_range(0, 9));
                1: wr_char = 8'h41 + 8'($urandom_range(0, 5));
                2: wr_char = 8'h61 + 8'($urandom_range(0, 5));
                3: wr_char = 8'h20;
                4: wr_char = 8'h2D;
                default: wr_char = 8'($urandom_range(0, 255));
            endcase
            step();
        end
        clear = 1'b0;
        wr_valid = 1'b1;
        wr_char = "8";
        step();
        wr_valid = 1'b0;

        // asynchronous reset while digit 2 is lit
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if (lit_now(n) && digit_now(n) == 2) found = 1'b1;
            else step();
        end
        chk("find_idx2", {31'd0, found}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_an", {28'd0, an}, 32'hF);
        chk("async_rst_seg", {25'd0, seg}, 32'h7F);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        repeat (30) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
